wb_stage: RTL

- Writeback stage of the pipelined processor; sits between the MEM stage and the register file.
- Accepts one retiring instruction per cycle over a valid/ready handshake.
- For loads, waits for the data-memory response, then aligns and extends the load data.
- Drives the register file write port (writeReg/writeData/writeEnable) from registered outputs, so they are stable before the register file's negedge write. Also exposes forwarding and retire-count outputs.

---
 rtl/wb_pkg.sv | 21 ++
 rtl/load_align.sv | 38 +++
 rtl/wb_stage.sv | 119 +++++++++++
 3 files changed

// File: rtl/wb_pkg.sv
// Shared encodings and widths for the writeback stage.
package wb_pkg;

    localparam int unsigned WB_DATA_W     = 32;
    localparam int unsigned WB_REG_ADDR_W = 5;
    localparam int unsigned WB_CNT_W      = 32;

    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_LOAD = 2'd1;
    localparam logic [1:0] WB_PC4  = 2'd2;

    localparam logic [1:0] LS_B = 2'd0;
    localparam logic [1:0] LS_H = 2'd1;
    localparam logic [1:0] LS_W = 2'd2;

    typedef enum logic {
        ST_READY    = 1'b0,
        ST_WAIT_MEM = 1'b1
    } wb_state_e;

endpackage

// File: rtl/load_align.sv
// Extracts the addressed byte/half/word from a memory word and sign/zero-extends it.
module load_align
    import wb_pkg::*;
(
    input  logic [WB_DATA_W-1:0] i_rdata,
    input  logic [1:0]           i_addr,
    input  logic [1:0]           i_size,
    input  logic                 i_unsigned,
    output logic [WB_DATA_W-1:0] o_data,
    output logic                 o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = i_rdata[8*i_addr +: 8];
    assign w_half = i_rdata[16*i_addr[1] +: 16];

    always_comb begin
        o_data       = i_rdata;
        o_misaligned = 1'b0;
        case (i_size)
            LS_B: begin
                o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
            end
            LS_H: begin
                o_data       = {{16{w_half[15] & ~i_unsigned}}, w_half};
                o_misaligned = i_addr[0];
            end
            default: begin
                // Word (and the reserved size code) requires full alignment.
                o_data       = i_rdata;
                o_misaligned = (i_addr != 2'd0);
            end
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// Writeback stage: retires one instruction per cycle, waits on the data memory for loads,
// and drives the register-file write port from registers.
module wb_stage
    import wb_pkg::*;
#(
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned REG_ADDR_W = WB_REG_ADDR_W
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [REG_ADDR_W-1:0] in_rd,
    input  logic                  in_reg_write,
    input  logic [1:0]            in_wb_sel,
    input  logic [DATA_W-1:0]     in_alu_result,
    input  logic [DATA_W-1:0]     in_pc_plus4,
    input  logic [1:0]            in_load_size,
    input  logic                  in_load_unsigned,
    input  logic                  flush,
    input  logic                  mem_rvalid,
    input  logic [DATA_W-1:0]     mem_rdata,
    output logic [REG_ADDR_W-1:0] writeReg,
    output logic [DATA_W-1:0]     writeData,
    output logic                  writeEnable,
    output logic                  load_err,
    output logic                  load_pending,
    output logic [WB_CNT_W-1:0]   retire_count
);

    wb_state_e             r_state;
    logic [REG_ADDR_W-1:0] r_rd;
    logic                  r_reg_write;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [1:0]            r_addr_lo;
    logic [REG_ADDR_W-1:0] r_write_reg;
    logic [DATA_W-1:0]     r_write_data;
    logic                  r_write_en;
    logic                  r_load_err;
    logic [WB_CNT_W-1:0]   r_retire;

    logic                  w_accept;
    logic [DATA_W-1:0]     w_ld_data;
    logic                  w_misaligned;

    assign w_accept = in_valid & ~flush & (r_state == ST_READY);

    load_align u_align (
        .i_rdata      (mem_rdata),
        .i_addr       (r_addr_lo),
        .i_size       (r_size),
        .i_unsigned   (r_unsigned),
        .o_data       (w_ld_data),
        .o_misaligned (w_misaligned)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state      <= ST_READY;
            r_rd         <= '0;
            r_reg_write  <= 1'b0;
            r_size       <= 2'd0;
            r_unsigned   <= 1'b0;
            r_addr_lo    <= 2'd0;
            r_write_reg  <= '0;
            r_write_data <= '0;
            r_write_en   <= 1'b0;
            r_load_err   <= 1'b0;
            r_retire     <= '0;
        end else begin
            r_write_en <= 1'b0;
            r_load_err <= 1'b0;
            case (r_state)
                ST_READY: begin
                    if (w_accept) begin
                        if (in_wb_sel == WB_LOAD) begin
                            r_rd        <= in_rd;
                            r_reg_write <= in_reg_write;
                            r_size      <= in_load_size;
                            r_unsigned  <= in_load_unsigned;
                            r_addr_lo   <= in_alu_result[1:0];
                            r_state     <= ST_WAIT_MEM;
                        end else begin
                            r_write_en   <= in_reg_write & (in_rd != '0);
                            r_write_reg  <= in_rd;
                            r_write_data <= (in_wb_sel == WB_PC4) ? in_pc_plus4 : in_alu_result;
                            r_retire     <= r_retire + WB_CNT_W'(1);
                        end
                    end
                end
                ST_WAIT_MEM: begin
                    if (mem_rvalid) begin
                        // Misaligned loads retire but never touch the register file.
                        if (w_misaligned) begin
                            r_load_err <= 1'b1;
                        end else begin
                            r_write_en   <= r_reg_write & (r_rd != '0);
                            r_write_reg  <= r_rd;
                            r_write_data <= w_ld_data;
                        end
                        r_retire <= r_retire + WB_CNT_W'(1);
                        r_state  <= ST_READY;
                    end
                end
                default: r_state <= ST_READY;
            endcase
        end
    end

    assign in_ready     = (r_state != ST_WAIT_MEM);
    assign load_pending = (r_state == ST_WAIT_MEM);
    assign writeReg     = r_write_reg;
    assign writeData    = r_write_data;
    assign writeEnable  = r_write_en;
    assign load_err     = r_load_err;
    assign retire_count = r_retire;

endmodule
